pmod_adc_emu: RTL and testbench

Synthesizable emulator of the PmodADC analog front end (shift-register R-2R DAC, sample/hold, comparator). It answers the successive-approximation controller's `sh`/`ser`/`sclk`/`lclk` pins and drives `comp` back, so the controller can be exercised in hardware-in-the-loop and simulation without the analog board. A digital word on `analog_i` stands in for the analog input.

---
 rtl/pmod_adc_emu_if.sv | 22 ++
 rtl/pmod_adc_emu.sv | 57 +++++
 tb/tb_pmod_adc_emu.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pmod_adc_emu_if.sv
// pmod_adc_emu_if: pin bundle between a SAR controller and the PmodADC front-end emulator
interface pmod_adc_emu_if #(
    parameter int W = 14
);
    logic         sh;
    logic         ser;
    logic         sclk;
    logic         lclk;
    logic [W-1:0] analog;
    logic         comp;
    logic [W-1:0] dac_code;
    logic [W-1:0] held;
    logic         frame_err;
    modport master (
        output sh, ser, sclk, lclk, analog,
        input  comp, dac_code, held, frame_err
    );
    modport slave (
        input  sh, ser, sclk, lclk, analog,
        output comp, dac_code, held, frame_err
    );
endinterface

// File: rtl/pmod_adc_emu.sv
// pmod_adc_emu: PmodADC front-end emulator (shift-register DAC, sample/hold, comparator)
// answering a SAR controller's asynchronous pins; analog input is a digital word.
module pmod_adc_emu #(
    parameter int W        = 14,
    parameter int COMP_LAT = 1
) (
    input logic          clk_i,
    input logic          reset_ni,
    pmod_adc_emu_if.slave bus
);
    logic [2:0]          sclk_q, lclk_q;
    logic [1:0]          sh_q, ser_q;
    logic [W-1:0]        shreg, shreg_next, dac_code, held;
    logic [4:0]          bcnt, bcnt_next;
    logic [COMP_LAT-1:0] dly;
    logic                sclk_rise, lclk_rise, frame_err;

    // A shift and a latch in the same cycle latch the freshly shifted word.
    always_comb begin
        sclk_rise  = sclk_q[1] & ~sclk_q[2];
        lclk_rise  = lclk_q[1] & ~lclk_q[2];
        shreg_next = sclk_rise ? {shreg[W-2:0], ser_q[1]} : shreg;
        bcnt_next  = (sclk_rise && bcnt != 5'd31) ? bcnt + 5'd1 : bcnt;
    end

    // sh needs no edge detect: held simply follows analog while tracking.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sclk_q    <= '0;
            lclk_q    <= '0;
            sh_q      <= '0;
            ser_q     <= '0;
            shreg     <= '0;
            bcnt      <= '0;
            dac_code  <= '0;
            held      <= '0;
            frame_err <= 1'b0;
            dly       <= '0;
        end else begin
            sclk_q    <= {sclk_q[1:0], bus.sclk};
            lclk_q    <= {lclk_q[1:0], bus.lclk};
            sh_q      <= {sh_q[0], bus.sh};
            ser_q     <= {ser_q[0], bus.ser};
            shreg     <= shreg_next;
            bcnt      <= lclk_rise ? '0 : bcnt_next;
            dac_code  <= lclk_rise ? shreg_next : dac_code;
            held      <= sh_q[1] ? bus.analog : held;
            frame_err <= lclk_rise && bcnt_next != 5'(W);
            dly       <= (dly << 1) | COMP_LAT'(held >= dac_code);
        end
    end

    assign bus.comp      = dly[COMP_LAT-1];
    assign bus.dac_code  = dac_code;
    assign bus.held      = held;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_pmod_adc_emu.sv
// tb_pmod_adc_emu: randomized bench with a word-level reference model and a SAR controller
module tb_pmod_adc_emu;
    localparam int W    = 14;
    localparam int LAT  = 1;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    pmod_adc_emu_if #(.W(W)) bus ();
    pmod_adc_emu #(.W(W), .COMP_LAT(LAT)) dut (.clk_i(clk), .reset_ni(reset_ni), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int m_sh = 0, m_cnt = 0, m_dac = 0, m_held = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int b);
        bus.ser = b[0];
        tick(4);
        bus.sclk = 1'b1;
        tick(4);
        bus.sclk = 1'b0;
        m_sh  = ((m_sh << 1) | (b & 1)) & MASK;
        m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
    endtask

    task automatic send_frame(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit((v >> i) & 1);
    endtask

    task automatic latch();
        int old_cmp, new_cmp, err;
        old_cmp = (m_held >= m_dac) ? 1 : 0;
        bus.lclk = 1'b1;
        tick(2);
        check("dac_before", bus.dac_code, m_dac);
        tick(1);
        err   = (m_cnt != W) ? 1 : 0;
        m_dac = m_sh;
        m_cnt = 0;
        new_cmp = (m_held >= m_dac) ? 1 : 0;
        check("dac_latched", bus.dac_code, m_dac);
        check("frame_err", bus.frame_err, err);
        tick(LAT - 1);
        check("comp_before", bus.comp, old_cmp);
        tick(1);
        check("comp_after", bus.comp, new_cmp);
        check("frame_err_width", bus.frame_err, 0);
        bus.lclk = 1'b0;
        tick(4);
    endtask

    task automatic sample(input int a, input int after);
        bus.analog = a[W-1:0];
        bus.sh = 1'b1;
        tick(3);
        m_held = a;
        check("held_track", bus.held, m_held);
        bus.sh = 1'b0;
        tick(3);
        bus.analog = after[W-1:0];
        tick(2);
        check("held_frozen", bus.held, m_held);
    endtask

    task automatic sar(input int v);
        int res, trial;
        sample(v, $urandom & MASK);
        res = 0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = res | (1 << b);
            send_frame(trial, W);
            latch();
            if (bus.comp) res = trial;
        end
        check("sar_result", res, v);
    endtask

    initial begin
        bus.sh = 1'b0;
        bus.ser = 1'b0;
        bus.sclk = 1'b0;
        bus.lclk = 1'b0;
        bus.analog = '0;
        tick(3);
        check("rst_dac", bus.dac_code, 0);
        check("rst_held", bus.held, 0);
        check("rst_comp", bus.comp, 0);
        check("rst_err", bus.frame_err, 0);
        reset_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_err", bus.frame_err, 0);
            check("idle_dac", bus.dac_code, 0);
        end
        check("idle_comp", bus.comp, 1);

        send_frame(14'h2A5C, W);
        latch();
        check("frame_2a5c", bus.dac_code, 14'h2A5C);

        sample(14'h1F00, 14'h3FFF);
        check("held_1f00", bus.held, 14'h1F00);
        send_frame(14'h1F00, W);
        latch();
        check("comp_eq", bus.comp, 1);
        send_frame(14'h1F01, W);
        latch();
        check("comp_above", bus.comp, 0);

        send_frame($urandom & MASK, 13);
        latch();
        send_frame($urandom & MASK, W);
        latch();

        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) sample($urandom & MASK, $urandom & MASK);
            else begin
                send_frame($urandom, (r < 7) ? W : $urandom_range(W - 4, W + 3));
                latch();
            end
        end

        sar(14'h0ABC);
        sar(14'h0000);
        sar(14'h3FFF);

        for (int i = 0; i < 7; i++) send_bit($urandom & 1);
        reset_ni = 1'b0;
        tick(1);
        reset_ni = 1'b1;
        m_sh = 0;
        m_cnt = 0;
        m_dac = 0;
        m_held = 0;
        check("midrst_dac", bus.dac_code, 0);
        check("midrst_held", bus.held, 0);
        send_frame(1, W);
        latch();
        check("midrst_frame", bus.dac_code, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
